// File: rtl/m_ram_initiator.sv
// Single-outstanding initiator that turns core byte/half/word load-store requests
// into lane-aligned STB/WE/SEL bus cycles against the 64 KiB SRAM responder.
module m_ram_initiator #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [15:0] req_adr,
  input  logic [31:0] req_wdat,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdat,
  output logic        STB_O,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic [15:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  // state | meaning
  // IDLE  | ready for a request, bus quiet
  // BUS   | strobe held until ACK_I or timeout
  // RESP  | one-cycle response pulse
  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  localparam logic [7:0] TC = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic        stb_d, we_d;
  logic [3:0]  sel_d;
  logic [15:0] adr_d;
  logic [31:0] dat_d;
  logic        rsp_valid_d, rsp_err_d;
  logic [31:0] rsp_rdat_d;

  logic        illegal;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  assign req_ready = (state_q == ST_IDLE);

  always_comb begin
    illegal = 1'b0;
    req_sel = 4'b1111;
    req_dat = req_wdat;
    case (req_size)
      2'b00: begin
        req_sel = 4'b0001 << req_adr[1:0];
        req_dat = {4{req_wdat[7:0]}};
      end
      2'b01: begin
        illegal = req_adr[0];
        req_sel = 4'b0011 << {req_adr[1], 1'b0};
        req_dat = {2{req_wdat[15:0]}};
      end
      2'b10: illegal = (req_adr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

  // Lane extraction uses the latched size and the address still held on ADR_O
  always_comb begin
    shamt = 5'd0;
    case (size_q)
      2'b00:   shamt = {ADR_O[1:0], 3'b000};
      2'b01:   shamt = {ADR_O[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    rd_shift = DAT_I >> shamt;
    case (size_q)
      2'b00:   rd_ext = {{24{signed_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rd_ext = {{16{signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = DAT_I;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    signed_d    = signed_q;
    stb_d       = 1'b0;
    we_d        = 1'b0;
    sel_d       = 4'b0000;
    adr_d       = ADR_O;
    dat_d       = 32'd0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdat_d  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        if (req_valid) begin
          size_d   = req_size;
          signed_d = req_signed;
          if (illegal) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_BUS;
            stb_d   = 1'b1;
            we_d    = req_we;
            sel_d   = req_sel;
            adr_d   = req_adr;
            dat_d   = req_we ? req_dat : 32'd0;
          end
        end
      end
      ST_BUS: begin
        if (ACK_I) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdat_d  = WE_O ? 32'd0 : rd_ext;
        end else if (cnt_q == TC) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end else begin
          stb_d = 1'b1;
          we_d  = WE_O;
          sel_d = SEL_O;
          dat_d = DAT_O;
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      STB_O     <= 1'b0;
      WE_O      <= 1'b0;
      SEL_O     <= 4'b0000;
      ADR_O     <= 16'd0;
      DAT_O     <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdat  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      STB_O     <= stb_d;
      WE_O      <= we_d;
      SEL_O     <= sel_d;
      ADR_O     <= adr_d;
      DAT_O     <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdat  <= rsp_rdat_d;
    end
  end

endmodule
